// File: rtl/fpga_proc_pkg.sv
// fpga_proc_pkg: shared sequencer state encoding, memory target codes and word width
package fpga_proc_pkg;
    localparam int DATA_W = 16;
    localparam logic TARGET_DRAM = 1'b0;
    localparam logic TARGET_IRAM = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_RUN} state_t;
endpackage

// File: rtl/mem_port_mux.sv
// mem_port_mux: hands the IRAM/DRAM ports to the core while running, to the loader otherwise
module mem_port_mux #(
    parameter int DATA_W  = 16,
    parameter int IRAM_AW = 9,
    parameter int DRAM_AW = 9
) (
    input  logic               i_run,
    input  logic [IRAM_AW-1:0] i_ld_iram_addr,
    input  logic [DRAM_AW-1:0] i_ld_dram_addr,
    input  logic [DATA_W-1:0]  i_ld_wdata,
    input  logic               i_ld_iram_we,
    input  logic               i_ld_dram_we,
    input  logic [IRAM_AW-1:0] i_pc_addr,
    input  logic [DRAM_AW-1:0] i_d_addr,
    input  logic [DATA_W-1:0]  i_d_wdata,
    input  logic               i_d_we,
    output logic [IRAM_AW-1:0] o_iram_addr,
    output logic [DATA_W-1:0]  o_iram_wdata,
    output logic               o_iram_we,
    output logic [DRAM_AW-1:0] o_dram_addr,
    output logic [DATA_W-1:0]  o_dram_wdata,
    output logic               o_dram_we
);
    // core only fetches from IRAM, so IRAM is never written while running
    always_comb begin
        o_iram_addr  = i_run ? i_pc_addr : i_ld_iram_addr;
        o_iram_wdata = i_ld_wdata;
        o_iram_we    = i_run ? 1'b0 : i_ld_iram_we;
        o_dram_addr  = i_run ? i_d_addr : i_ld_dram_addr;
        o_dram_wdata = i_run ? i_d_wdata : i_ld_wdata;
        o_dram_we    = i_run ? i_d_we : i_ld_dram_we;
    end
endmodule

// File: rtl/mem_load_sequencer.sv
// mem_load_sequencer: streams words into IRAM/DRAM with a fixed write-hold window, then runs the core
module mem_load_sequencer #(
    parameter int DATA_W    = fpga_proc_pkg::DATA_W,
    parameter int IRAM_AW   = 9,
    parameter int DRAM_AW   = 9,
    parameter int BASE_ADDR = 1,
    parameter int WR_HOLD   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_req,
    input  logic               load_sel,
    input  logic [IRAM_AW-1:0] load_len,
    input  logic               s_valid,
    input  logic [DATA_W-1:0]  s_data,
    output logic               s_ready,
    input  logic               run_req,
    input  logic               proc_halt,
    input  logic [IRAM_AW-1:0] proc_pc_addr,
    input  logic [DRAM_AW-1:0] proc_d_addr,
    input  logic [DATA_W-1:0]  proc_d_wdata,
    input  logic               proc_d_we,
    output logic [IRAM_AW-1:0] iram_addr,
    output logic [DATA_W-1:0]  iram_wdata,
    output logic               iram_we,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic [DATA_W-1:0]  dram_wdata,
    output logic               dram_we,
    output logic               start,
    output logic               busy,
    output logic               load_done,
    output logic               load_err
);
    import fpga_proc_pkg::*;
    localparam int LAW = (IRAM_AW > DRAM_AW) ? IRAM_AW : DRAM_AW;
    localparam int HW  = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(WR_HOLD - 1);
    localparam logic [LAW-1:0] IRAM_MAX  = LAW'((2 ** IRAM_AW) - 1);
    localparam logic [LAW-1:0] DRAM_MAX  = LAW'((2 ** DRAM_AW) - 1);
    state_t             r_state;
    logic               r_sel;
    logic [IRAM_AW-1:0] r_len;
    logic [IRAM_AW-1:0] r_cnt;
    logic [LAW-1:0]     r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [HW-1:0]      r_hold;
    logic               r_s_ready;
    logic               r_iram_we;
    logic               r_dram_we;
    logic               r_start;
    logic               r_busy;
    logic               r_load_done;
    logic               r_load_err;
    logic [IRAM_AW-1:0] w_cnt_nxt;
    logic               w_at_max;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_at_max  = (r_sel == TARGET_IRAM) ? (r_addr == IRAM_MAX) : (r_addr == DRAM_MAX);
    assign s_ready   = r_s_ready;
    assign start     = r_start;
    assign busy      = r_busy;
    assign load_done = r_load_done;
    assign load_err  = r_load_err;
    // load/run sequencer; every output is a register updated alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_hold      <= '0;
            r_s_ready   <= 1'b0;
            r_iram_we   <= 1'b0;
            r_dram_we   <= 1'b0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_req) begin
                        r_load_err <= run_req;
                        if (load_len == '0) begin
                            r_load_done <= 1'b1;
                        end else begin
                            r_sel     <= load_sel;
                            r_len     <= load_len;
                            r_cnt     <= '0;
                            r_addr    <= LAW'(BASE_ADDR);
                            r_s_ready <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= S_ACCEPT;
                        end
                    end else if (run_req) begin
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_ACCEPT: begin
                    r_load_err <= load_req | run_req;
                    if (s_valid && r_s_ready) begin
                        r_data    <= s_data;
                        r_s_ready <= 1'b0;
                        r_hold    <= '0;
                        r_iram_we <= (r_sel == TARGET_IRAM);
                        r_dram_we <= (r_sel == TARGET_DRAM);
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_load_err <= load_req | run_req;
                    r_hold     <= r_hold + 1'b1;
                    if (r_hold == HOLD_LAST) begin
                        r_iram_we <= 1'b0;
                        r_dram_we <= 1'b0;
                        r_cnt     <= w_cnt_nxt;
                        if (w_cnt_nxt == r_len) begin
                            r_load_done <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else if (w_at_max) begin
                            r_load_err <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_addr    <= r_addr + 1'b1;
                            r_s_ready <= 1'b1;
                            r_state   <= S_ACCEPT;
                        end
                    end
                end
                S_RUN: begin
                    r_load_err <= load_req | run_req;
                    if (proc_halt) begin
                        r_start <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    mem_port_mux #(.DATA_W(DATA_W), .IRAM_AW(IRAM_AW), .DRAM_AW(DRAM_AW)) u_mux (
        .i_run          (r_state == S_RUN),
        .i_ld_iram_addr (r_addr[IRAM_AW-1:0]),
        .i_ld_dram_addr (r_addr[DRAM_AW-1:0]),
        .i_ld_wdata     (r_data),
        .i_ld_iram_we   (r_iram_we),
        .i_ld_dram_we   (r_dram_we),
        .i_pc_addr      (proc_pc_addr),
        .i_d_addr       (proc_d_addr),
        .i_d_wdata      (proc_d_wdata),
        .i_d_we         (proc_d_we),
        .o_iram_addr    (iram_addr),
        .o_iram_wdata   (iram_wdata),
        .o_iram_we      (iram_we),
        .o_dram_addr    (dram_addr),
        .o_dram_wdata   (dram_wdata),
        .o_dram_we      (dram_we)
    );
endmodule
